// File: rtl/fft_reorder_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_reorder_buf_if
// Description : Streaming bus bundle for fft_reorder_buf. It carries the frame
//               size configuration, the natural-order input stream and the
//               bit-reversed output stream.
//   cfg_log2n          frame size exponent, captured with the first sample
//   in_valid/in_ready  input handshake; din_r/din_i signed sample
//   out_valid/out_ready output handshake; dout_r/dout_i signed sample,
//                      out_index position k, out_last marks k = N-1
//   modport slave  : the reorder buffer
//   modport master : the producer/consumer driving the buffer
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_reorder_buf_if #(
  parameter int LOG2N = 6,
  parameter int WIDTH = 16
);
  logic [3:0]              cfg_log2n;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] din_r;
  logic signed [WIDTH-1:0] din_i;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] dout_r;
  logic signed [WIDTH-1:0] dout_i;
  logic [LOG2N-1:0]        out_index;
  logic                    out_last;

  modport slave (
    input  cfg_log2n, in_valid, din_r, din_i, out_ready,
    output in_ready, out_valid, dout_r, dout_i, out_index, out_last
  );

  modport master (
    output cfg_log2n, in_valid, din_r, din_i, out_ready,
    input  in_ready, out_valid, dout_r, dout_i, out_index, out_last
  );
endinterface
`default_nettype wire

// File: rtl/fft_reorder_buf.sv
`default_nettype none
// ============================================================================
// Module      : fft_reorder_buf
// Description : Ping-pong frame buffer converting natural-order FFT samples
//               into bit-reversed order. Two banks of 2^LOG2N complex words;
//               each bank remembers the frame size it was filled with, so
//               consecutive frames may differ in size.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - fft_reorder_buf_if.slave (config, input and output
//                      streams)
// Revision    : 1.0 - initial release
// ============================================================================
module fft_reorder_buf #(
  parameter int LOG2N = 6,
  parameter int WIDTH = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  fft_reorder_buf_if.slave  bus
);

  localparam int NMAX = 1 << LOG2N;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } bank_state_e;

  // Bank storage and per-bank bookkeeping
  logic [2*WIDTH-1:0] mem_q [2][NMAX];
  bank_state_e        bank_st_q [2];
  bank_state_e        bank_st_d [2];
  logic [3:0]         bank_l_q  [2];

  // Write side
  logic               wr_sel_q;
  logic [LOG2N-1:0]   wr_cnt_q;

  // Read side: rd_sel_q is the bank being (or next to be) issued; it moves on
  // as soon as the last address of a frame is issued so the next frame can
  // follow without a bubble. out_bank_q remembers which bank the word in the
  // output register came from, so that bank is released on its out_last.
  logic               rd_sel_q;
  logic [LOG2N-1:0]   rd_cnt_q;
  logic               out_bank_q;

  // Registered outputs
  logic               out_valid_q;
  logic               out_last_q;
  logic [LOG2N-1:0]   out_index_q;
  logic [WIDTH-1:0]   dout_r_q;
  logic [WIDTH-1:0]   dout_i_q;

  // Combinational helpers
  logic [3:0]         w_cfg_l;
  logic [3:0]         w_wr_l;
  logic [LOG2N-1:0]   w_wr_mask;
  logic               w_wr_last;
  logic               w_wr_open;
  logic               w_in_ready;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_release;
  logic               w_rd_avail;
  logic               w_load;
  logic [3:0]         w_rd_l;
  logic [LOG2N-1:0]   w_rd_mask;
  logic               w_rd_last;
  logic [LOG2N-1:0]   w_rd_addr;
  logic [2*WIDTH-1:0] w_rd_word;

  // Effective frame exponent: clamp to 1..LOG2N
  always_comb begin
    if (bus.cfg_log2n == 4'd0) begin
      w_cfg_l = 4'd1;
    end else if (bus.cfg_log2n > 4'(LOG2N)) begin
      w_cfg_l = 4'(LOG2N);
    end else begin
      w_cfg_l = bus.cfg_log2n;
    end
  end

  // The first sample of a frame uses the live config; later samples use the
  // exponent latched into the bank at that first sample.
  assign w_wr_l = (wr_cnt_q == '0) ? w_cfg_l : bank_l_q[wr_sel_q];
  assign w_rd_l = bank_l_q[rd_sel_q];

  // N-1 masks for the write and read frames
  always_comb begin
    w_wr_mask = '0;
    w_rd_mask = '0;
    for (int i = 0; i < LOG2N; i++) begin
      w_wr_mask[i] = (i < int'(w_wr_l));
      w_rd_mask[i] = (i < int'(w_rd_l));
    end
  end

  assign w_wr_last  = (wr_cnt_q == w_wr_mask);
  assign w_rd_last  = (rd_cnt_q == w_rd_mask);

  assign w_out_xfer = out_valid_q && bus.out_ready;
  assign w_release  = w_out_xfer && out_last_q;

  // A bank whose final word is leaving this cycle is already fully read, so
  // it may take the first sample of the next frame in the same cycle.
  assign w_wr_open  = (bank_st_q[wr_sel_q] == ST_EMPTY) ||
                      (bank_st_q[wr_sel_q] == ST_FILLING);
  assign w_in_ready = !rst &&
                      (w_wr_open ||
                       ((bank_st_q[wr_sel_q] == ST_DRAINING) && w_release &&
                        (out_bank_q == wr_sel_q)));
  assign w_in_xfer  = bus.in_valid && w_in_ready;

  // Issue a read whenever the output register is free or being emptied and
  // the read bank has words left to issue.
  assign w_rd_avail = (bank_st_q[rd_sel_q] == ST_FULL) ||
                      (bank_st_q[rd_sel_q] == ST_DRAINING);
  assign w_load     = (!out_valid_q || bus.out_ready) && w_rd_avail;

  // Reverse the low L bits of the read position; upper address bits stay 0
  always_comb begin
    w_rd_addr = '0;
    for (int i = 0; i < LOG2N; i++) begin
      for (int j = 0; j < LOG2N; j++) begin
        if ((i < int'(w_rd_l)) && (j == int'(w_rd_l) - 1 - i)) begin
          w_rd_addr[i] = rd_cnt_q[j];
        end
      end
    end
  end

  assign w_rd_word = mem_q[rd_sel_q][w_rd_addr];

  // Bank state machines: next state
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_st_d[b] = bank_st_q[b];
      if (w_release && (out_bank_q == 1'(b))) begin
        bank_st_d[b] = ST_EMPTY;
      end
      if (w_load && (rd_sel_q == 1'(b)) && (bank_st_q[b] == ST_FULL)) begin
        bank_st_d[b] = ST_DRAINING;
      end
      // A write into a bank releasing this cycle wins over the release
      if (w_in_xfer && (wr_sel_q == 1'(b))) begin
        bank_st_d[b] = w_wr_last ? ST_FULL : ST_FILLING;
      end
    end
  end

  // Bank state machines: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st_q[0] <= ST_EMPTY;
      bank_st_q[1] <= ST_EMPTY;
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
    end
  end

  // Sample storage (contents are not cleared by reset)
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      mem_q[wr_sel_q][wr_cnt_q] <= {bus.din_r, bus.din_i};
    end
  end

  // Counters, bank selects and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel_q    <= 1'b0;
      wr_cnt_q    <= '0;
      rd_sel_q    <= 1'b0;
      rd_cnt_q    <= '0;
      out_bank_q  <= 1'b0;
      bank_l_q[0] <= 4'd1;
      bank_l_q[1] <= 4'd1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
    end else begin
      if (w_in_xfer) begin
        if (wr_cnt_q == '0) begin
          bank_l_q[wr_sel_q] <= w_cfg_l;
        end
        if (w_wr_last) begin
          wr_cnt_q <= '0;
          wr_sel_q <= ~wr_sel_q;
        end else begin
          wr_cnt_q <= wr_cnt_q + LOG2N'(1);
        end
      end

      if (w_load) begin
        dout_r_q    <= w_rd_word[2*WIDTH-1:WIDTH];
        dout_i_q    <= w_rd_word[WIDTH-1:0];
        out_index_q <= rd_cnt_q;
        out_last_q  <= w_rd_last;
        out_bank_q  <= rd_sel_q;
        out_valid_q <= 1'b1;
        if (w_rd_last) begin
          rd_cnt_q <= '0;
          rd_sel_q <= ~rd_sel_q;
        end else begin
          rd_cnt_q <= rd_cnt_q + LOG2N'(1);
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_index = out_index_q;
  assign bus.dout_r    = dout_r_q;
  assign bus.dout_i    = dout_i_q;

endmodule
`default_nettype wire
